// File: rtl/regfile_wb_arb_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | regfile_wb_arb_if : ALU/load producer ports and regfile write port       |
// | pend_mask exists only with REGFILE_WB_ARB_PEND_EN    Rev 1.0             |
// +--------------------------------------------------------------------------+
interface regfile_wb_arb_if #(
  parameter int N_BITS = 32,
  parameter int N_REGS = 32
);
  localparam int N_IDX = $clog2(N_REGS);

  logic              a_valid;
  logic              a_ready;
  logic [N_IDX-1:0]  a_idx;
  logic [N_BITS-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [N_IDX-1:0]  b_idx;
  logic [N_BITS-1:0] b_data;
  logic              wr_en;
  logic [N_IDX-1:0]  wr_idx;
  logic [N_BITS-1:0] wr_data;
`ifdef REGFILE_WB_ARB_PEND_EN
  logic [N_REGS-1:0] pend_mask;

  modport master (
    output a_valid, a_idx, a_data, b_valid, b_idx, b_data,
    input  a_ready, b_ready, wr_en, wr_idx, wr_data, pend_mask
  );
  modport slave (
    input  a_valid, a_idx, a_data, b_valid, b_idx, b_data,
    output a_ready, b_ready, wr_en, wr_idx, wr_data, pend_mask
  );
`else
  modport master (
    output a_valid, a_idx, a_data, b_valid, b_idx, b_data,
    input  a_ready, b_ready, wr_en, wr_idx, wr_data
  );
  modport slave (
    input  a_valid, a_idx, a_data, b_valid, b_idx, b_data,
    output a_ready, b_ready, wr_en, wr_idx, wr_data
  );
`endif
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | regfile_wb_arb : two-port writeback arbiter, per-port FIFOs, round robin |
// | Option macro REGFILE_WB_ARB_PEND_EN adds pend_mask   Rev 1.0             |
// +--------------------------------------------------------------------------+
module regfile_wb_arb #(
  parameter int N_BITS     = 32,
  parameter int N_REGS     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  regfile_wb_arb_if.slave bus
);
  localparam int N_IDX = $clog2(N_REGS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = N_IDX + N_BITS;
  localparam logic [PW:0] c_ptr_one = 1;

  // Port 0 is A (ALU), port 1 is B (load); r_prio == 0 favours A.
  logic [EW-1:0]     r_mem [2][FIFO_DEPTH];
  logic [PW:0]       r_wp [2];
  logic [PW:0]       r_rp [2];
  logic              r_prio;
  logic              r_wr_en;
  logic [N_IDX-1:0]  r_wr_idx;
  logic [N_BITS-1:0] r_wr_data;

  logic [1:0]        w_in_valid;
  logic [EW-1:0]     w_in_ent [2];
  logic [1:0]        w_full;
  logic [1:0]        w_ne;
  logic [1:0]        w_rdy;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [EW-1:0]     w_head;

  assign w_in_valid  = {bus.b_valid, bus.a_valid};
  assign w_in_ent[0] = {bus.a_idx, bus.a_data};
  assign w_in_ent[1] = {bus.b_idx, bus.b_data};

  always_comb begin
    w_full = '0;
    w_ne   = '0;
    for (int p = 0; p < 2; p++) begin
      w_full[p] = (r_wp[p][PW] != r_rp[p][PW]) && (r_wp[p][PW-1:0] == r_rp[p][PW-1:0]);
      w_ne[p]   = (r_wp[p] != r_rp[p]);
    end
  end

  assign w_rdy    = ~w_full & {2{~rst}};
  assign w_push   = w_in_valid & w_rdy;
  assign w_pop[0] = w_ne[0] & (~w_ne[1] | ~r_prio);
  assign w_pop[1] = w_ne[1] & (~w_ne[0] | r_prio);
  assign w_head   = w_pop[1] ? r_mem[1][r_rp[1][PW-1:0]] : r_mem[0][r_rp[0][PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        r_wp[p] <= '0;
        r_rp[p] <= '0;
      end
      r_prio <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_push[p]) r_wp[p] <= r_wp[p] + c_ptr_one;
        if (w_pop[p])  r_rp[p] <= r_rp[p] + c_ptr_one;
      end
      if (w_pop[0])      r_prio <= 1'b1;
      else if (w_pop[1]) r_prio <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (w_push[p]) r_mem[p][r_wp[p][PW-1:0]] <= w_in_ent[p];
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if ((|w_pop) && (w_head[EW-1:N_BITS] != '0)) begin
        r_wr_en   <= 1'b1;
        r_wr_idx  <= w_head[EW-1:N_BITS];
        r_wr_data <= w_head[N_BITS-1:0];
      end
    end
  end

  assign bus.a_ready = w_rdy[0];
  assign bus.b_ready = w_rdy[1];
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_idx  = r_wr_idx;
  assign bus.wr_data = r_wr_data;

`ifdef REGFILE_WB_ARB_PEND_EN
  logic [N_REGS-1:0] w_pend;
  logic [PW:0]       w_cnt;
  logic [PW-1:0]     w_off;

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    w_pend = '0;
    w_cnt  = '0;
    w_off  = '0;
    for (int p = 0; p < 2; p++) begin
      w_cnt = r_wp[p] - r_rp[p];
      for (int s = 0; s < FIFO_DEPTH; s++) begin
        w_off = PW'(s) - r_rp[p][PW-1:0];
        if ({1'b0, w_off} < w_cnt) w_pend[r_mem[p][s][EW-1:N_BITS]] = 1'b1;
      end
    end
    if (r_wr_en) w_pend[r_wr_idx] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign bus.pend_mask = w_pend;
`endif
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arb : scoreboard bench for regfile_wb_arb                  |
// | Build with REGFILE_WB_ARB_PEND_EN to also check pend_mask   Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arb;
  localparam int N_BITS = 32;
  localparam int N_REGS = 32;
  localparam int N_IDX  = 5;
  localparam int D      = 2;

  typedef struct packed {
    logic [N_IDX-1:0]  idx;
    logic [N_BITS-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arb_if #(.N_BITS(N_BITS), .N_REGS(N_REGS)) bus ();

  regfile_wb_arb #(.N_BITS(N_BITS), .N_REGS(N_REGS), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   idle_pct = 0;
  ent_t src_a[$], src_b[$];
  ent_t mq_a[$], mq_b[$];
  ent_t exp_q[$];
  bit   m_prio;
  ent_t last;

  function automatic ent_t mk(input logic [N_IDX-1:0] i, input logic [N_BITS-1:0] d);
    ent_t e;
    e.idx  = i;
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: two bounded queues, alternating priority, x0 writes dropped.
  always @(posedge clk or posedge rst) begin
    bit   acc_a, acc_b, ga, gb;
    ent_t e;
    if (rst) begin
      mq_a.delete();
      mq_b.delete();
      exp_q.delete();
      m_prio = 1'b0;
    end else begin
      acc_a = bus.a_valid && (mq_a.size() < D);
      acc_b = bus.b_valid && (mq_b.size() < D);
      ga = (mq_a.size() > 0) && ((mq_b.size() == 0) || !m_prio);
      gb = (mq_b.size() > 0) && !ga;
      if (ga) begin
        e = mq_a.pop_front();
        m_prio = 1'b1;
        if (e.idx != 0) exp_q.push_back(e);
      end else if (gb) begin
        e = mq_b.pop_front();
        m_prio = 1'b0;
        if (e.idx != 0) exp_q.push_back(e);
      end
      if (acc_a) mq_a.push_back(mk(bus.a_idx, bus.a_data));
      if (acc_b) mq_b.push_back(mk(bus.b_idx, bus.b_data));
    end
  end

  // Monitor: compares the registered write port against the scoreboard.
  always @(negedge clk) begin
    ent_t e;
    logic [N_REGS-1:0] pm;
    if (rst) begin
      chk("rst_wr_en",   64'(bus.wr_en),   64'(0));
      chk("rst_wr_idx",  64'(bus.wr_idx),  64'(0));
      chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
      chk("rst_a_ready", 64'(bus.a_ready), 64'(0));
      chk("rst_b_ready", 64'(bus.b_ready), 64'(0));
      last = '0;
    end else begin
      chk("a_ready", 64'(bus.a_ready), 64'(mq_a.size() < D));
      chk("b_ready", 64'(bus.b_ready), 64'(mq_b.size() < D));
      chk("wr_en",   64'(bus.wr_en),   64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bus.wr_en) begin
          chk("wr_idx",  64'(bus.wr_idx),  64'(e.idx));
          chk("wr_data", 64'(bus.wr_data), 64'(e.data));
        end
        last = e;
      end else if (!bus.wr_en) begin
        chk("hold_idx",  64'(bus.wr_idx),  64'(last.idx));
        chk("hold_data", 64'(bus.wr_data), 64'(last.data));
      end
`ifdef REGFILE_WB_ARB_PEND_EN
      pm = '0;
      foreach (mq_a[i]) pm[mq_a[i].idx] = 1'b1;
      foreach (mq_b[i]) pm[mq_b[i].idx] = 1'b1;
      if (bus.wr_en) pm[last.idx] = 1'b1;
      pm[0] = 1'b0;
      chk("pend_mask", 64'(bus.pend_mask), 64'(pm));
`endif
    end
  end

  task automatic cycle();
    bit acc_a, acc_b;
    bus.a_valid = (src_a.size() > 0) && ($urandom_range(99) >= idle_pct);
    bus.b_valid = (src_b.size() > 0) && ($urandom_range(99) >= idle_pct);
    if (src_a.size() > 0) begin
      bus.a_idx  = src_a[0].idx;
      bus.a_data = src_a[0].data;
    end
    if (src_b.size() > 0) begin
      bus.b_idx  = src_b[0].idx;
      bus.b_data = src_b[0].data;
    end
    @(negedge clk);
    acc_a = bus.a_valid && bus.a_ready;
    acc_b = bus.b_valid && bus.b_ready;
    @(posedge clk);
    #1;
    if (acc_a) void'(src_a.pop_front());
    if (acc_b) void'(src_b.pop_front());
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((src_a.size() + src_b.size() + mq_a.size() + mq_b.size() + exp_q.size()) != 0
           && n < 200) begin
      cycle();
      n++;
    end
    chk({"drain_timeout_", name}, 64'(n >= 200), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    src_a.delete();
    src_b.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_idx   = '0;
    bus.b_idx   = '0;
    bus.a_data  = '0;
    bus.b_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    src_a.push_back(mk(5'd5, 32'hDEADBEEF));
    drain("single");

    src_a.push_back(mk(5'd3, 32'h11));
    src_b.push_back(mk(5'd4, 32'h22));
    drain("contention");

    for (int i = 0; i < 5; i++)  src_b.push_back(mk(N_IDX'(8 + i), 32'hB000_0000 + 32'(i)));
    for (int i = 0; i < 10; i++) src_a.push_back(mk(N_IDX'(16 + i), 32'hA000_0000 + 32'(i)));
    drain("backpressure");

    src_a.push_back(mk(5'd0, 32'hFFFFFFFF));
    drain("x0_drop");

    for (int i = 0; i < 6; i++) begin
      src_a.push_back(mk(N_IDX'(1 + i), 32'hC000_0000 + 32'(i)));
      src_b.push_back(mk(N_IDX'(9 + i), 32'hD000_0000 + 32'(i)));
    end
    repeat (4) cycle();
    do_reset();
    repeat (6) cycle();

    src_b.push_back(mk(5'd7, 32'h77));
    drain("pend");

    idle_pct = 25;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) < 4 && src_a.size() < 4)
        src_a.push_back(mk(($urandom_range(7) == 0) ? 5'd0 : N_IDX'($urandom_range(31)), $urandom));
      if ($urandom_range(9) < 4 && src_b.size() < 4)
        src_b.push_back(mk(($urandom_range(7) == 0) ? 5'd0 : N_IDX'($urandom_range(31)), $urandom));
      cycle();
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter N_BITS, default 32, meaning the data width.
REQ-002 SHALL have parameter N_REGS, default 32, meaning the register count; N_IDX = $clog2(N_REGS).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the per-port queue depth; legal values are powers of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports a_valid  input  1, a_ready  output  1, a_idx  input  N_IDX, a_data  input  N_BITS: ALU result port.
REQ-007 SHALL have ports b_valid  input  1, b_ready  output  1, b_idx  input  N_IDX, b_data  input  N_BITS: load result port.
REQ-008 SHALL have ports wr_en  output  1, wr_idx  output  N_IDX, wr_data  output  N_BITS: regfile write port, all registered.
REQ-009 SHALL have port pend_mask  output  N_REGS: per-register pending-write flags (present only under REQ-026).

Function
REQ-010 SHALL give each port a FIFO_DEPTH-entry FIFO.
REQ-011 SHALL drive x_ready = !full_x, registered state only, with no combinational path from x_valid.
REQ-012 SHALL enqueue {x_idx, x_data} at a rising edge when x_valid && x_ready.
REQ-013 SHALL ignore x_valid while full and SHALL leave the entry uncaptured.
REQ-014 SHALL grant each cycle at most one non-empty FIFO head.
- If only one FIFO is non-empty, it is granted.
- If both are non-empty, the FIFO selected by the 1-bit prio register is granted.
REQ-015 SHALL set prio to the non-granted port after every grant; with no grant, prio holds.
REQ-016 SHALL pop the granted head at the edge and register it into wr_*.
- wr_en = 1 for exactly one cycle.
- wr_idx and wr_data update.
REQ-017 SHALL, for a granted entry with idx == 0, pop it with wr_en = 0 and leave wr_idx/wr_data unchanged.
REQ-018 SHALL hold wr_idx/wr_data at their last written values when there is no grant, with wr_en = 0.
REQ-019 SHALL give a latency of one edge from acceptance to output.
- An entry accepted at edge N into an empty, uncontended FIFO is granted at edge N+1.
- wr_en is high in the cycle after edge N+1.
- No same-cycle bypass from input to output.
REQ-020 SHALL preserve per-port order.
- Cross-port order equals grant order.
- Two same-idx writes from different ports commit in grant order.
REQ-021 SHALL allow push and pop on the same FIFO in one edge; occupancy is then unchanged.
REQ-022 SHALL wrap pointers modulo FIFO_DEPTH, using an extra wrap bit to distinguish full from empty.

Reset
REQ-023 SHALL, while rst is high, set the following asynchronously:
- FIFOs empty, a_ready = b_ready = 1 once released.
- prio = port A.
- wr_en = 0, wr_idx = 0, wr_data = 0.
- pend_mask = 0.
REQ-024 SHALL, on reset mid-operation, discard all queued and in-flight entries; no wr_en pulse occurs for them after release.
REQ-025 SHALL drive a_ready and b_ready low while rst is asserted.

Configuration
REQ-026 SHALL, with macro REGFILE_WB_ARB_PEND_EN defined, implement pend_mask.
- Bit i (i != 0) is high iff any FIFO entry holds idx i.
- Bit i is also high iff wr_en is high with wr_idx == i.
- Bit 0 is always 0.
- Computed combinationally from registered state.
REQ-027 SHALL, without REGFILE_WB_ARB_PEND_EN, omit the pend_mask port and its logic entirely; all other behaviour is identical.

Verification
REQ-028 SHALL cover single write: a_valid=1, a_idx=5, a_data=0xDEADBEEF for one cycle -> one cycle later wr_en=1, wr_idx=5, wr_data=0xDEADBEEF for exactly one cycle.
REQ-029 SHALL cover contention: A(idx 3, 0x11) and B(idx 4, 0x22) accepted at the same edge after reset -> A committed first, then B on the next cycle; prio ends at A.
REQ-030 SHALL cover backpressure: hold b_valid=1 with 5 distinct entries while A streams continuously.
- b_ready drops at 2 entries queued.
- All 5 B entries commit in order.
- A and B grants alternate.
- No entry is lost or duplicated.
REQ-031 SHALL cover the x0 drop: a_idx=0, a_data=0xFFFFFFFF accepted -> wr_en stays 0, the FIFO empties, and wr_idx/wr_data are unchanged.
REQ-032 SHALL cover reset mid-operation: both FIFOs full, rst pulsed for 1 cycle -> all outputs are 0 during reset, with no wr_en pulse afterwards.
REQ-033 SHALL cover pend_mask with PEND_EN defined: B(idx 7) queued -> pend_mask[7]=1 until the cycle after the wr_en pulse for idx 7, then 0.
